// File: rtl/fp_add_arbiter_if.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter_if
// Bundles the arbiter's client, adder and response signals.
//   slave  : the arbiter itself
//   master : the clients plus the shared adder (or a testbench standing in)
// Signals:
//   req_valid/req_ready/req_a/req_b/req_sub : per-requester issue channel
//   fpu_start/fpu_x1/fpu_x2/fpu_done/fpu_result : shared adder handshake
//   rsp_valid/rsp_ready/rsp_result : per-requester response channel
//   err_spurious : sticky flag, adder done seen while not waiting for it
// ----------------------------------------------------------------------------
interface fp_add_arbiter_if #(
    parameter int N_REQ = 4
) ();
    logic [N_REQ-1:0]       req_valid;
    logic [N_REQ-1:0]       req_ready;
    logic [N_REQ-1:0][31:0] req_a;
    logic [N_REQ-1:0][31:0] req_b;
    logic [N_REQ-1:0]       req_sub;

    logic                   fpu_start;
    logic [31:0]            fpu_x1;
    logic [31:0]            fpu_x2;
    logic                   fpu_done;
    logic [31:0]            fpu_result;

    logic [N_REQ-1:0]       rsp_valid;
    logic [N_REQ-1:0]       rsp_ready;
    logic [31:0]            rsp_result;

    logic                   err_spurious;

    modport slave (
        input  req_valid, req_a, req_b, req_sub, fpu_done, fpu_result, rsp_ready,
        output req_ready, fpu_start, fpu_x1, fpu_x2, rsp_valid, rsp_result, err_spurious
    );

    modport master (
        output req_valid, req_a, req_b, req_sub, fpu_done, fpu_result, rsp_ready,
        input  req_ready, fpu_start, fpu_x1, fpu_x2, rsp_valid, rsp_result, err_spurious
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// fp_add_arbiter
// Shares one multi-cycle single-precision adder between N_REQ requesters.
// Round-robin grant, operand capture (B sign flipped for subtract), start/done
// sequencing of the adder and response return to the owning requester. One
// operation is in flight at a time.
//
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   bus   : fp_add_arbiter_if.slave (request, adder and response channels)
//
// Optional feature macro: FP_ARB_ZERO_BYPASS_EN
//   When defined, an operation whose A or B is +/-0 skips the adder and
//   answers directly with the other operand.
// ----------------------------------------------------------------------------
module fp_add_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic           clk,
    input  logic           rst_n,
    fp_add_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic [31:0]      x1_q;
    logic [31:0]      x2_q;
    logic [31:0]      rsp_q;
    logic             err_q;

    // Round-robin search result.
    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;

    // Operands of the granted requester; B already carries the subtract flip.
    logic [31:0]      sel_a;
    logic [31:0]      sel_b;
    logic             bypass;
    logic [31:0]      bypass_result;

    // ------------------------------------------------------------------------
    // Grant: first valid requester starting one past the pointer, wrapping.
    // ------------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr_q;
        cand      = ptr_q;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = IDX_W'((int'(ptr_q) + off) % N_REQ);
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    assign sel_a = bus.req_a[gnt_idx];
    assign sel_b = bus.req_b[gnt_idx] ^ {bus.req_sub[gnt_idx], 31'b0};

`ifdef FP_ARB_ZERO_BYPASS_EN
    logic a_zero;
    logic b_zero;

    // +/-0: exponent and mantissa both zero, sign ignored.
    assign a_zero = (sel_a[30:0] == 31'b0);
    assign b_zero = (sel_b[30:0] == 31'b0);
    assign bypass = a_zero | b_zero;

    always_comb begin
        bypass_result = sel_a;
        if (a_zero && b_zero)
            bypass_result = {sel_a[31] & sel_b[31], sel_a[30:0]};
        else if (a_zero)
            bypass_result = sel_b;
    end
`else
    assign bypass        = 1'b0;
    assign bypass_result = 32'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (gnt_found) state_d = bypass ? RESP : ISSUE;
            ISSUE: state_d = WAIT;
            WAIT:  if (bus.fpu_done) state_d = RESP;
            RESP:  if (bus.rsp_ready[owner_q]) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= IDX_W'(N_REQ - 1);
            owner_q <= '0;
            x1_q    <= 32'b0;
            x2_q    <= 32'b0;
            rsp_q   <= 32'b0;
            err_q   <= 1'b0;
        end else begin
            if (state_q == IDLE && gnt_found) begin
                owner_q <= gnt_idx;
                ptr_q   <= gnt_idx;
                x1_q    <= sel_a;
                x2_q    <= sel_b;
                if (bypass)
                    rsp_q <= bypass_result;
            end
            if (state_q == WAIT && bus.fpu_done)
                rsp_q <= bus.fpu_result;
            // A done pulse we are not waiting for is a protocol error; sticky.
            if (bus.fpu_done && state_q != WAIT)
                err_q <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.req_ready    = (state_q == IDLE && gnt_found) ? (N_REQ'(1) << gnt_idx) : '0;
    assign bus.rsp_valid    = (state_q == RESP) ? (N_REQ'(1) << owner_q) : '0;
    assign bus.fpu_start    = (state_q == ISSUE);
    assign bus.fpu_x1       = x1_q;
    assign bus.fpu_x2       = x2_q;
    assign bus.rsp_result   = rsp_q;
    assign bus.err_spurious = err_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ----------------------------------------------------------------------------
// tb_fp_add_arbiter
// Directed bench for fp_add_arbiter (N_REQ=4). The bench plays both the
// clients and the shared adder; inputs change on the falling edge and outputs
// are sampled 1 time unit later, well away from the rising edge.
// ----------------------------------------------------------------------------
module tb_fp_add_arbiter;

    localparam int N_REQ = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fp_add_arbiter_if #(.N_REQ(N_REQ)) bus ();

    fp_add_arbiter #(.N_REQ(N_REQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One complete operation, starting in the current IDLE cycle (just after
    // a falling edge). The adder answers two cycles after the start pulse.
    // The owner's rsp_ready is held low for 'stall' RESP cycles.
    task automatic do_op(input logic [3:0] valid_vec, input logic [3:0] after_vec,
                         input logic [1:0] g, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [31:0] result, input int stall);
        logic [3:0]  oh;
        logic [31:0] exp_x2;
        oh     = 4'b0001 << g;
        exp_x2 = b ^ {sub, 31'b0};

        // IDLE: combinational grant
        bus.req_a[g]  = a;
        bus.req_b[g]  = b;
        bus.req_sub[g] = sub;
        bus.req_valid = valid_vec;
        bus.rsp_ready = '1;
        #1;
        check("grant", 32'(bus.req_ready), 32'(oh));

        // ISSUE
        @(negedge clk);
        bus.req_valid = after_vec;
        #1;
        check("start_pulse", 32'(bus.fpu_start), 32'd1);
        check("fpu_x1", bus.fpu_x1, a);
        check("fpu_x2", bus.fpu_x2, exp_x2);
        check("ready_in_issue", 32'(bus.req_ready), 32'd0);

        // WAIT, first cycle
        @(negedge clk);
        #1;
        check("start_once", 32'(bus.fpu_start), 32'd0);
        check("x2_held", bus.fpu_x2, exp_x2);

        // WAIT, adder done
        @(negedge clk);
        bus.fpu_done   = 1'b1;
        bus.fpu_result = result;
        #1;
        check("no_rsp_in_wait", 32'(bus.rsp_valid), 32'd0);

        // RESP
        @(negedge clk);
        bus.fpu_done   = 1'b0;
        bus.fpu_result = ~result;
        if (stall > 0)
            bus.rsp_ready = ~oh;
        #1;
        check("rsp_valid", 32'(bus.rsp_valid), 32'(oh));
        check("rsp_result", bus.rsp_result, result);

        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            if (s == stall)
                bus.rsp_ready = '1;
            #1;
            check("stall_rsp_valid", 32'(bus.rsp_valid), 32'(oh));
            check("stall_rsp_result", bus.rsp_result, result);
            check("stall_no_ready", 32'(bus.req_ready), 32'd0);
        end

        // Back in IDLE
        @(negedge clk);
        #1;
        check("rsp_dropped", 32'(bus.rsp_valid), 32'd0);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.req_valid  = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_sub    = '0;
        bus.fpu_done   = 1'b0;
        bus.fpu_result = 32'b0;
        bus.rsp_ready  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'd0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rst_fpu_start", 32'(bus.fpu_start), 32'd0);
        check("rst_fpu_x1", bus.fpu_x1, 32'd0);
        check("rst_fpu_x2", bus.fpu_x2, 32'd0);
        check("rst_rsp_result", bus.rsp_result, 32'd0);
        check("rst_err", 32'(bus.err_spurious), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single add on requester 0: 1.0 + 2.0 = 3.0
        do_op(4'b0001, 4'b0000, 2'd0, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 0);

        // Subtract on requester 2: 3.0 - 1.0, B sign flipped
        do_op(4'b0100, 4'b0000, 2'd2, 32'h4040_0000, 32'h3F80_0000, 1'b1, 32'h4000_0000, 0);
        check("err_clean", 32'(bus.err_spurious), 32'd0);

        // Reset during WAIT, then a stale done pulse
        bus.req_a[1]  = 32'h40E0_0000;
        bus.req_b[1]  = 32'h4080_0000;
        bus.req_sub[1] = 1'b0;
        bus.req_valid = 4'b0010;
        #1;
        check("abort_grant", 32'(bus.req_ready), 32'b0010);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("abort_start", 32'(bus.fpu_start), 32'd1);
        @(negedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_x1", bus.fpu_x1, 32'd0);
        check("abort_x2", bus.fpu_x2, 32'd0);
        check("abort_start_low", 32'(bus.fpu_start), 32'd0);
        check("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("abort_rsp_result", bus.rsp_result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus.fpu_done   = 1'b1;
        bus.fpu_result = 32'h4130_0000;
        #1;
        check("err_before_edge", 32'(bus.err_spurious), 32'd0);
        @(negedge clk);
        bus.fpu_done = 1'b0;
        #1;
        check("err_sticky_set", 32'(bus.err_spurious), 32'd1);
        check("stale_no_rsp", 32'(bus.rsp_valid), 32'd0);
        check("stale_rsp_result", bus.rsp_result, 32'd0);

        // All four requesting continuously: grants 0,1,2,3,0
        for (int k = 0; k < 5; k++) begin
            do_op(4'b1111, 4'b1111, 2'(k), 32'h3F80_0000 + 32'(k), 32'h4000_0000 + 32'(k << 8),
                  1'(k & 1), 32'h4100_0000 + 32'(k), 0);
        end

        // Backpressure on requester 1 with requester 3 also waiting
        do_op(4'b1010, 4'b1010, 2'd1, 32'h4120_0000, 32'hC0A0_0000, 1'b1, 32'h4170_0000, 6);
        check("resume_grant", 32'(bus.req_ready), 32'b1000);
        bus.req_valid = 4'b0000;
        #1;
        check("drop_before_grant", 32'(bus.req_ready), 32'd0);
        check("err_still_set", 32'(bus.err_spurious), 32'd1);

`ifdef FP_ARB_ZERO_BYPASS_EN
        // Zero bypass: 0 - 5.0 = -5.0 without the adder
        @(negedge clk);
        bus.req_a[2]  = 32'h0000_0000;
        bus.req_b[2]  = 32'h40A0_0000;
        bus.req_sub[2] = 1'b1;
        bus.req_valid = 4'b0100;
        bus.rsp_ready = '1;
        #1;
        check("byp_grant", 32'(bus.req_ready), 32'b0100);
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        check("byp_no_start", 32'(bus.fpu_start), 32'd0);
        check("byp_rsp_valid", 32'(bus.rsp_valid), 32'b0100);
        check("byp_rsp_result", bus.rsp_result, 32'hC0A0_0000);
        @(negedge clk);
        #1;
        check("byp_done", 32'(bus.rsp_valid), 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
